imem_uart_boot_loader: RTL and testbench
========================================

Name: imem_uart_boot_loader

Overview:
- Boot controller for the pipeline CPU.
- Holds the core stalled while it receives a framed program image from the UART receiver byte stream.
- Assembles little-endian 32-bit words and writes them into instruction memory through a dedicated write port.
- Releases the core once the checksum verifies. Sits between the UART RX byte interface and the CPU's instruction-memory write port and enable input.

Parameters:
- INSTR_MEM_DEPTH, 64: instruction memory depth in words; maximum loadable word count.
- ADDR_W, 6: instruction memory word-address width; must satisfy 2^ADDR_W >= INSTR_MEM_DEPTH.
- TIMEOUT_CYCLES, 1000000: inter-byte timeout in clk cycles. Used only with BOOT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received UART byte
- reload  input  1  level; in RUN returns the loader to IDLE and re-stalls the CPU
- imem_we  output  1  instruction memory write strobe
- imem_addr  output  ADDR_W  instruction memory word address
- imem_wdata  output  32  instruction word
- cpu_hold  output  1  1 = CPU held (drives CPU enable low)
- done  output  1  image loaded and verified; CPU running
- error  output  1  framing, length, checksum or timeout failure
- words_loaded  output  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State = IDLE.
  - cpu_hold=1, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, words_loaded=0.
  - Internal byte index and checksum are cleared.
  - Reset mid-load aborts with no further writes; partially written memory is not cleaned.
- Frame format: 0xA5 sync, count byte N (words), 4N payload bytes (LSB first per word), checksum byte = XOR of all 4N payload bytes.
- Bytes are consumed only in cycles with rx_valid=1.
- States:
  - IDLE: bytes other than 0xA5 are ignored; 0xA5 -> LEN.
  - LEN:
    - N=0 or N>INSTR_MEM_DEPTH -> ERR.
    - Otherwise latch N; clear words_loaded, byte index and checksum -> DATA.
  - DATA:
    - Shift each byte into the word at byte position 0..3 and XOR it into the checksum.
    - On the 4th byte, the next cycle has imem_we=1 for exactly one cycle, imem_addr=words_loaded (pre-increment) and imem_wdata=assembled word; words_loaded then increments.
    - After word N-1 is accepted -> CHK.
  - CHK: byte == checksum -> RUN; else -> ERR.
  - RUN:
    - cpu_hold=0, done=1. rx_valid is ignored.
    - reload=1 -> IDLE with cpu_hold=1 and done=0 the next cycle; words_loaded is kept.
  - ERR:
    - error=1, cpu_hold=1, done=0.
    - Byte 0xA5 -> LEN and error clears; other bytes are ignored.
- cpu_hold=1 in every state except RUN. done and error are never both 1.
- imem_we is never asserted outside DATA.
- Address wrap cannot occur because N<=INSTR_MEM_DEPTH.
- reload in any state other than RUN is ignored.
- A 0xA5 byte inside DATA is payload, not a resync.

Optional Feature:
- Macro: BOOT_TIMEOUT_EN.
- With the macro:
  - An inter-byte counter runs in LEN, DATA and CHK and resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES -> ERR the next cycle.
  - The counter is held at 0 in IDLE, RUN and ERR.
- Without the macro: no counter is built; the loader waits indefinitely for bytes; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, then bytes A5 01 93 00 50 00 C3 -> one imem_we with addr 0, wdata 0x00500093; cpu_hold falls; done=1; words_loaded=1.
- Bytes A5 02, then words 0x11223344 and 0xAABBCCDD, checksum 0x44 -> writes addr0=0x11223344, addr1=0xAABBCCDD; done=1.
- Same frame as the first test but checksum 0x00 -> error=1; cpu_hold stays 1; done=0. Then send the valid frame -> error clears, done=1.
- Count byte 0x00, or 0x41 with depth 64 -> ERR immediately; no imem_we pulses.
- In RUN pulse reload=1, then send stray bytes 12 34 -> cpu_hold=1, done=0; IDLE ignores the bytes; no writes.
- BOOT_TIMEOUT_EN with TIMEOUT_CYCLES=100: send A5 02 93 then stall 100 cycles -> error=1 and no write. Also assert rst_n=0 mid-DATA -> all outputs return to reset values.

Source files
------------

// File: rtl/imem_uart_boot_loader_if.sv
// Loader bus: UART RX byte strobe in, instruction-memory write port out.
// master = boot loader side, slave = UART receiver / instruction memory side.
interface imem_uart_boot_loader_if #(
  parameter int ADDR_W = 6
);
  // rx_valid is a one-cycle strobe with no back-pressure: rx_data is consumed
  // in exactly the cycles where rx_valid=1. imem_we is a one-cycle write pulse
  // qualifying imem_addr/imem_wdata; the memory always accepts it.
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_uart_boot_loader.sv
// Boot loader: receives A5/N/payload/XOR frames over UART and writes the image into imem.
// Optional inter-byte timeout is built only when BOOT_TIMEOUT_EN is defined.
module imem_uart_boot_loader #(
  parameter int INSTR_MEM_DEPTH = 64,
  parameter int ADDR_W          = 6,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  imem_uart_boot_loader_if.master     bus,
  input  logic                        reload,
  output logic                        cpu_hold,
  output logic                        done,
  output logic                        error,
  output logic [ADDR_W:0]             words_loaded,
  output logic [2:0]                  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] MAX_N     = 8'(INSTR_MEM_DEPTH);

  if ((1 << ADDR_W) < INSTR_MEM_DEPTH || INSTR_MEM_DEPTH > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("imem_uart_boot_loader: inconsistent parameters");
  end

  state_t          state;
  logic [ADDR_W:0] count;
  logic [1:0]      byte_idx;
  logic [23:0]     word_buf;
  logic [7:0]      chk;
  logic            last_written;
  logic            timeout_hit;

  assign state_dbg = state;
  // The final word's write pulse is still in flight; DATA hands over to CHK here.
  assign last_written = bus.imem_we && (words_loaded == count);

`ifdef BOOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting     = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign timeout_hit = waiting && !bus.rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (waiting && !bus.rx_valid && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
      count          <= '0;
      byte_idx       <= '0;
      word_buf       <= '0;
      chk            <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (timeout_hit) begin
        state <= S_ERR;
        error <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state <= S_LEN;
          S_LEN: if (bus.rx_valid) begin
            if (bus.rx_data == 8'd0 || bus.rx_data > MAX_N) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              count        <= (ADDR_W+1)'(bus.rx_data);
              words_loaded <= '0;
              byte_idx     <= '0;
              chk          <= '0;
              state        <= S_DATA;
            end
          end
          S_DATA: begin
            if (last_written) begin
              // A checksum byte landing in the write cycle is judged right away.
              if (bus.rx_valid) begin
                if (bus.rx_data == chk) begin
                  state <= S_RUN; cpu_hold <= 1'b0; done <= 1'b1;
                end else begin
                  state <= S_ERR; error <= 1'b1;
                end
              end else begin
                state <= S_CHK;
              end
            end else if (bus.rx_valid) begin
              chk      <= chk ^ bus.rx_data;
              byte_idx <= byte_idx + 1'b1;
              word_buf <= {bus.rx_data, word_buf[23:8]};
              if (byte_idx == 2'd3) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= words_loaded[ADDR_W-1:0];
                bus.imem_wdata <= {bus.rx_data, word_buf};
                words_loaded   <= words_loaded + 1'b1;
              end
            end
          end
          S_CHK: if (bus.rx_valid) begin
            if (bus.rx_data == chk) begin
              state <= S_RUN; cpu_hold <= 1'b0; done <= 1'b1;
            end else begin
              state <= S_ERR; error <= 1'b1;
            end
          end
          S_RUN: if (reload) begin
            state    <= S_IDLE;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
          end
          S_ERR: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state <= S_LEN;
            error <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_boot_loader.sv
// Bench for imem_uart_boot_loader: frame-level model, write scoreboard, random frames.
module tb_imem_uart_boot_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
`ifdef BOOT_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1000000;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reload = 1'b0;
  logic cpu_hold, done, error;
  logic [ADDR_W:0] words_loaded;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  imem_uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_uart_boot_loader #(
    .INSTR_MEM_DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .reload(reload),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] got_q[$];
  logic [31:0] fw[DEPTH];

  // write monitor
  always @(negedge clk) if (bus.imem_we) got_q.push_back({bus.imem_addr, bus.imem_wdata});

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic pulse_reload();
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    @(negedge clk);
  endtask

  // reference model: sends a frame of fw[0..n-1], records expected writes,
  // reports whether the checksum byte sent is the XOR of the payload
  task automatic send_frame(input int n, input int chk_ovr, output bit ok);
    logic [7:0] x;
    logic [7:0] cb;
    x = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({ADDR_W'(w), fw[w]});
      for (int b = 0; b < 4; b++) begin
        logic [7:0] by;
        by = fw[w][8*b +: 8];
        x  = x ^ by;
        send_byte(by);
      end
    end
    cb = (chk_ovr < 0) ? x : 8'(chk_ovr);
    send_byte(cb);
    ok = (cb == x);
    @(negedge clk);
  endtask

  // scoreboard
  task automatic score_writes(input string tag);
    logic [ADDR_W+31:0] g, e;
    vec_cnt++;
    if (got_q.size() != exp_q.size()) begin
      err_cnt++;
      $display("FAIL %s_wr_count got %0d exp %0d", tag, got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      vec_cnt++;
      if (g !== e) begin
        err_cnt++;
        $display("FAIL %s_wr got addr %0d data %h exp addr %0d data %h",
                 tag, g[ADDR_W+31:32], g[31:0], e[ADDR_W+31:32], e[31:0]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({cpu_hold, done, error, bus.imem_we, bus.imem_addr, bus.imem_wdata, words_loaded} !==
        {1'b1, 1'b0, 1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, {(ADDR_W+1){1'b0}}}) begin
      err_cnt++;
      $display("FAIL reset_outputs got hold %b done %b err %b we %b addr %0d wdata %h wl %0d exp 1 0 0 0 0 0 0",
               cpu_hold, done, error, bus.imem_we, bus.imem_addr, bus.imem_wdata, words_loaded);
    end
    rst_n = 1'b1;
    got_q.delete();
  endtask

  task automatic test_single_word();
    bit ok;
    fw[0] = 32'h00500093;
    send_frame(1, 'hC3, ok);
    vec_cnt++;
    if ({done, cpu_hold, error, words_loaded} !== {ok, 1'b0, 1'b0, 7'd1}) begin
      err_cnt++;
      $display("FAIL single_status got done %b hold %b err %b wl %0d exp %b 0 0 1", done, cpu_hold, error, words_loaded, ok);
    end
    score_writes("single");
  endtask

  task automatic test_two_words();
    bit ok;
    pulse_reload();
    fw[0] = 32'h11223344;
    fw[1] = 32'hAABBCCDD;
    send_frame(2, 'h44, ok);
    vec_cnt++;
    if ({done, cpu_hold, error, words_loaded} !== {1'b1, 1'b0, 1'b0, 7'd2}) begin
      err_cnt++;
      $display("FAIL two_status got done %b hold %b err %b wl %0d exp 1 0 0 2", done, cpu_hold, error, words_loaded);
    end
    score_writes("two");
  endtask

  task automatic test_bad_checksum();
    bit ok;
    pulse_reload();
    fw[0] = 32'h00500093;
    send_frame(1, 'h00, ok);
    vec_cnt++;
    if ({error, cpu_hold, done} !== {1'b1, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL badchk_status got err %b hold %b done %b exp 1 1 0", error, cpu_hold, done);
    end
    score_writes("badchk");
    send_frame(1, -1, ok);
    vec_cnt++;
    if ({error, cpu_hold, done} !== {1'b0, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL badchk_recover got err %b hold %b done %b exp 0 0 1", error, cpu_hold, done);
    end
    score_writes("recover");
  endtask

  task automatic test_bad_length();
    pulse_reload();
    send_byte(8'hA5); send_byte(8'h00);
    vec_cnt++;
    if ({error, cpu_hold, done} !== {1'b1, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL len0 got err %b hold %b done %b exp 1 1 0", error, cpu_hold, done);
    end
    send_byte(8'hA5);
    vec_cnt++;
    if (error !== 1'b0) begin
      err_cnt++;
      $display("FAIL err_resync got err %b exp 0", error);
    end
    send_byte(8'(DEPTH + 1));
    vec_cnt++;
    if ({error, cpu_hold, done} !== {1'b1, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL len_over got err %b hold %b done %b exp 1 1 0", error, cpu_hold, done);
    end
    score_writes("badlen");
  endtask

  task automatic test_reload();
    bit ok;
    fw[0] = 32'hDEADBEEF;
    fw[1] = 32'h0BADF00D;
    send_frame(2, -1, ok);
    score_writes("pre_reload");
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
    vec_cnt++;
    if ({cpu_hold, done, error} !== {1'b1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reload_state got hold %b done %b err %b exp 1 0 0", cpu_hold, done, error);
    end
    send_byte(8'h12); send_byte(8'h34);
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({cpu_hold, done, error, words_loaded} !== {1'b1, 1'b0, 1'b0, 7'd2}) begin
      err_cnt++;
      $display("FAIL reload_idle got hold %b done %b err %b wl %0d exp 1 0 0 2", cpu_hold, done, error, words_loaded);
    end
    score_writes("stray");
  endtask

  task automatic test_random_frames();
    bit ok;
    int n;
    for (int it = 0; it < 8; it++) begin
      if (done) pulse_reload();
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 8'hA4)));
      n = (it == 0) ? DEPTH : $urandom_range(1, 8);
      for (int w = 0; w < n; w++) fw[w] = $urandom;
      send_frame(n, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1, ok);
      vec_cnt++;
      if ({done, error, cpu_hold, words_loaded} !== {ok, !ok, !ok, 7'(n)}) begin
        err_cnt++;
        $display("FAIL rand%0d_status got done %b err %b hold %b wl %0d exp %b %b %b %0d",
                 it, done, error, cpu_hold, words_loaded, ok, !ok, !ok, n);
      end
      score_writes("rand");
    end
  endtask

  task automatic test_reset_mid_data();
    if (done) pulse_reload();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({cpu_hold, done, error, bus.imem_we, bus.imem_addr, bus.imem_wdata, words_loaded} !==
        {1'b1, 1'b0, 1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, {(ADDR_W+1){1'b0}}}) begin
      err_cnt++;
      $display("FAIL midreset_outputs got hold %b done %b err %b we %b addr %0d wdata %h wl %0d",
               cpu_hold, done, error, bus.imem_we, bus.imem_addr, bus.imem_wdata, words_loaded);
    end
    rst_n = 1'b1;
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    score_writes("midreset");
  endtask

`ifdef BOOT_TIMEOUT_EN
  task automatic test_timeout();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h93);
    repeat (90) @(negedge clk);
    vec_cnt++;
    if (error !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_early got err %b exp 0", error);
    end
    repeat (15) @(negedge clk);
    vec_cnt++;
    if ({error, cpu_hold, done} !== {1'b1, 1'b1, 1'b0}) begin
      err_cnt++;
      $display("FAIL timeout got err %b hold %b done %b exp 1 1 0", error, cpu_hold, done);
    end
    score_writes("timeout");
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_single_word();
    test_two_words();
    test_bad_checksum();
    test_bad_length();
    test_reload();
    test_random_frames();
    test_reset_mid_data();
`ifdef BOOT_TIMEOUT_EN
    test_reset();
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
